// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt sequencer: line count,
// default subroutine vectors, FSM state encoding and the priority encoder.
package irq_pkg;

    localparam int N_IRQ = 4;
    localparam int IDX_W = 2;
    localparam int DIR_W = 10;

    localparam logic [DIR_W-1:0] VEC0_DEF = 10'd824;
    localparam logic [DIR_W-1:0] VEC1_DEF = 10'd874;
    localparam logic [DIR_W-1:0] VEC2_DEF = 10'd924;
    localparam logic [DIR_W-1:0] VEC3_DEF = 10'd974;

    typedef enum logic {IDLE, REQ} state_t;

    // Lowest set bit wins (bit 0 is the highest priority line).
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } prio_t;

    function automatic prio_t prio_enc(input logic [N_IRQ-1:0] req);
        prio_t r;
        r.vld = 1'b0;
        r.idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.vld = 1'b1;
                r.idx = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-flop synchroniser followed by a rising-edge
// detector. The pulse is combinational off the synchronised flops so the
// pending latch sees it two edges after the line is first sampled.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic rise
);

    logic s1, s2, prev;

    // Synchronise the asynchronous line and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= irq;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: synchronises four lines, latches rising edges as
// pending, applies a CPU-writable mask, issues one vector at a time via a
// request/ack handshake and tracks routines in service until fin.
// Optional macro IRQ_NEST_EN: lets a higher-priority line preempt a
// running routine; without it only one routine is ever in service.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter logic [DIR_W-1:0] VEC0     = VEC0_DEF,
    parameter logic [DIR_W-1:0] VEC1     = VEC1_DEF,
    parameter logic [DIR_W-1:0] VEC2     = VEC2_DEF,
    parameter logic [DIR_W-1:0] VEC3     = VEC3_DEF,
    parameter logic [N_IRQ-1:0] MASK_RST = 4'b1111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             irq_ack,
    input  logic             fin,
    output logic             s_interrup,
    output logic [DIR_W-1:0] dir,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic [N_IRQ-1:0] mask
);

    localparam logic [N_IRQ-1:0] ONE = {{(N_IRQ-1){1'b0}}, 1'b1};

    logic [N_IRQ-1:0]            rise;
    logic [N_IRQ-1:0][DIR_W-1:0] vec_tab;
    logic [N_IRQ-1:0]            eligible;
    prio_t                       win;
    prio_t                       ins_low;
    logic                        issue_ok;
    logic [N_IRQ-1:0]            fin_clr;
    logic [N_IRQ-1:0]            ack_set;
    logic [N_IRQ-1:0]            lock;
    state_t                      state;
    logic [IDX_W-1:0]            cur;

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_line
            irq_sync_edge u_sync (
                .clk   (clk),
                .reset (reset),
                .irq   (irq_in[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    assign vec_tab = {VEC3, VEC2, VEC1, VEC0};

    // Arbitration, issue rule and the per-edge set/clear masks.
    always_comb begin
        eligible = pending & mask & ~in_service;
        win      = prio_enc(eligible);
        ins_low  = prio_enc(in_service);
`ifdef IRQ_NEST_EN
        issue_ok = !ins_low.vld || (win.idx < ins_low.idx);
`else
        issue_ok = !ins_low.vld;
`endif
        fin_clr  = (fin && ins_low.vld) ? (ONE << ins_low.idx) : '0;
        ack_set  = (state == REQ && irq_ack) ? (ONE << cur) : '0;
        lock     = (state == REQ) ? (ONE << cur) : '0;
    end

    // Request FSM with registered request level, vector and winner index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            s_interrup <= 1'b0;
            dir        <= '0;
            cur        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win.vld && issue_ok) begin
                        state      <= REQ;
                        s_interrup <= 1'b1;
                        dir        <= vec_tab[win.idx];
                        cur        <= win.idx;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state      <= IDLE;
                        s_interrup <= 1'b0;
                        dir        <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    s_interrup <= 1'b0;
                    dir        <= '0;
                end
            endcase
        end
    end

    // Pending/in-service bookkeeping; a new edge beats an ack clear, and the
    // committed line's mask bit is frozen while its request is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            in_service <= '0;
            mask       <= MASK_RST;
        end else begin
            pending    <= (pending & ~ack_set) | rise;
            in_service <= (in_service & ~fin_clr) | ack_set;
            if (mask_we)
                mask <= (mask_wdata & ~lock) | (mask & lock);
        end
    end

endmodule
